// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants, FSM encoding and lane-slice helper for the systolic input skew feeder
package systolic_pkg;

    localparam int DEFAULT_DIMENSION = 4;
    localparam int DEFAULT_I_BITS    = 8;

    localparam int STATE_BITS = 2;

    localparam logic [STATE_BITS-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_BITS-1:0] ST_CLEAR  = 2'd1;
    localparam logic [STATE_BITS-1:0] ST_STREAM = 2'd2;
    localparam logic [STATE_BITS-1:0] ST_FLUSH  = 2'd3;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage {reset,data} token chain that shifts only on advance
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 9
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_advance,
    input  logic [W-1:0] i_token,
    output logic [W-1:0] o_token
);

    logic [W-1:0] stage_q [DEPTH];

    // Stage 0 is the input register; stages 1..DEPTH-1 provide the diagonal skew.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else if (i_advance) begin
            stage_q[0] <= i_token;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign o_token = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skew.sv
// rtl/systolic_input_skew.sv - diagonally skewed a/b edge feeder with reset tokens for an output-stationary array
module systolic_input_skew
    import systolic_pkg::*;
#(
    parameter int DIMENSION = DEFAULT_DIMENSION,
    parameter int I_BITS    = DEFAULT_I_BITS,
    parameter int CNT_BITS  = $clog2(DIMENSION + 1)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [DIMENSION*I_BITS-1:0]   i_a_col,
    input  logic [DIMENSION*I_BITS-1:0]   i_b_row,
    input  logic                          i_s_valid,
    output logic                          o_s_ready,
    output logic                          o_valid,
    output logic [DIMENSION*I_BITS-1:0]   o_a,
    output logic [DIMENSION*I_BITS-1:0]   o_b,
    output logic [DIMENSION-1:0]          o_a_reset,
    output logic [DIMENSION-1:0]          o_b_reset,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DIMENSION - 1);

    logic [STATE_BITS-1:0] state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  valid_q, valid_d;

    logic advance;
    logic stream_beat;
    logic inject_reset;
    logic done;

    assign stream_beat  = (state_q == ST_STREAM) && i_s_valid;
    assign inject_reset = (state_q == ST_CLEAR);
    assign advance      = (state_q == ST_CLEAR) || (state_q == ST_FLUSH) || stream_beat;
    assign valid_d      = advance;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
                cnt_d   = '0;
            end
            ST_STREAM: begin
                if (i_s_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // DIMENSION zero beats drain the longest lane completely.
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign o_s_ready = (state_q == ST_STREAM);
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = done;
    assign o_valid   = valid_q;

    for (genvar i = 0; i < DIMENSION; i++) begin : g_lane
        localparam int LSB = lane_lsb(i, I_BITS);

        logic [I_BITS:0] a_token_in, a_token_out;
        logic [I_BITS:0] b_token_in, b_token_out;

        // Outside STREAM the data field is zero: CLEAR carries only the reset flag, FLUSH is all zero.
        assign a_token_in = {inject_reset, stream_beat ? i_a_col[LSB +: I_BITS] : {I_BITS{1'b0}}};
        assign b_token_in = {inject_reset, stream_beat ? i_b_row[LSB +: I_BITS] : {I_BITS{1'b0}}};

        skew_delay_line #(
            .DEPTH (i + 1),
            .W     (I_BITS + 1)
        ) u_a_line (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_advance (advance),
            .i_token   (a_token_in),
            .o_token   (a_token_out)
        );

        skew_delay_line #(
            .DEPTH (i + 1),
            .W     (I_BITS + 1)
        ) u_b_line (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_advance (advance),
            .i_token   (b_token_in),
            .o_token   (b_token_out)
        );

        assign o_a[LSB +: I_BITS] = a_token_out[I_BITS-1:0];
        assign o_a_reset[i]       = a_token_out[I_BITS];
        assign o_b[LSB +: I_BITS] = b_token_out[I_BITS-1:0];
        assign o_b_reset[i]       = b_token_out[I_BITS];
    end

endmodule

// File: tb/tb_systolic_input_skew.sv
// tb/tb_systolic_input_skew.sv - self-checking bench for systolic_input_skew against a token-history reference model
module tb_systolic_input_skew;

    localparam int D  = 4;
    localparam int IB = 8;
    localparam int VW = D * IB;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [VW-1:0] i_a_col;
    logic [VW-1:0] i_b_row;
    logic          i_s_valid;
    logic          o_s_ready;
    logic          o_valid;
    logic [VW-1:0] o_a;
    logic [VW-1:0] o_b;
    logic [D-1:0]  o_a_reset;
    logic [D-1:0]  o_b_reset;
    logic          o_busy;
    logic          o_done;

    systolic_input_skew #(
        .DIMENSION (D),
        .I_BITS    (IB)
    ) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_a_col   (i_a_col),
        .i_b_row   (i_b_row),
        .i_s_valid (i_s_valid),
        .o_s_ready (o_s_ready),
        .o_valid   (o_valid),
        .o_a       (o_a),
        .o_b       (o_b),
        .o_a_reset (o_a_reset),
        .o_b_reset (o_b_reset),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        bit            rst;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } token_t;

    // Every injected column/row is remembered; lane i shows the token injected i+1 advances ago.
    token_t hist[$];
    int     phase;      // 0 idle, 1 clear, 2 stream, 3 flush
    int     beats;
    bit     exp_valid;
    int     n_cmp = 0;
    int     n_err = 0;
    int     n_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        phase     = 0;
        beats     = 0;
        exp_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_ready"}, 64'(o_s_ready), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_a"}, 64'(o_a), 64'd0);
        chk({tag, "_b"}, 64'(o_b), 64'd0);
        chk({tag, "_ar"}, 64'(o_a_reset), 64'd0);
        chk({tag, "_br"}, 64'(o_b_reset), 64'd0);
    endtask

    // Entered at posedge+1; drives one cycle, checks at negedge, updates the model at the next posedge.
    task automatic cycle(input bit start, input bit sv, input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] ea, eb;
        logic [D-1:0]  ear, ebr;
        bit            adv;
        bit            edone;
        token_t        t;
        i_start   = start;
        i_s_valid = sv;
        i_a_col   = a;
        i_b_row   = b;
        ea = '0; eb = '0; ear = '0; ebr = '0;
        for (int i = 0; i < D; i++) begin
            if (hist.size() > i) begin
                t = hist[hist.size() - 1 - i];
                ea[i*IB +: IB] = t.a[i*IB +: IB];
                eb[i*IB +: IB] = t.b[i*IB +: IB];
                ear[i] = t.rst;
                ebr[i] = t.rst;
            end
        end
        edone = (phase == 3) && (beats == D - 1);
        adv   = (phase == 1) || (phase == 3) || (phase == 2 && sv);
        @(negedge i_clock);
        chk("ready", 64'(o_s_ready), 64'(phase == 2));
        chk("busy", 64'(o_busy), 64'(phase != 0));
        chk("done", 64'(o_done), 64'(edone));
        chk("valid", 64'(o_valid), 64'(exp_valid));
        chk("o_a", 64'(o_a), 64'(ea));
        chk("o_b", 64'(o_b), 64'(eb));
        chk("o_a_reset", 64'(o_a_reset), 64'(ear));
        chk("o_b_reset", 64'(o_b_reset), 64'(ebr));
        if (o_done === 1'b1) n_done++;
        @(posedge i_clock);
        exp_valid = adv;
        if (adv) begin
            t.rst = (phase == 1);
            t.a   = (phase == 2) ? a : '0;
            t.b   = (phase == 2) ? b : '0;
            hist.push_back(t);
        end
        case (phase)
            0: if (start) phase = 1;
            1: begin phase = 2; beats = 0; end
            2: if (sv) begin
                   if (beats == D - 1) begin phase = 3; beats = 0; end
                   else beats++;
               end
            default: begin
                   if (beats == D - 1) begin phase = 0; beats = 0; end
                   else beats++;
               end
        endcase
        #1;
    endtask

    function automatic logic [VW-1:0] ident_col(input int k);
        logic [VW-1:0] v;
        v = '0;
        v[k*IB +: IB] = 8'h7F;
        return v;
    endfunction

    function automatic logic [VW-1:0] const_row(input int k);
        logic [VW-1:0] v;
        for (int j = 0; j < D; j++) v[j*IB +: IB] = 8'(k + 1);
        return v;
    endfunction

    initial begin
        i_reset   = 1'b1;
        i_start   = 1'b0;
        i_s_valid = 1'b0;
        i_a_col   = '0;
        i_b_row   = '0;
        model_reset();
        #2;
        check_all_zero("por");
        @(posedge i_clock); #1;
        i_reset = 1'b0;

        // Beats offered while idle are not consumed and nothing advances.
        repeat (3) cycle(1'b0, 1'b1, VW'($urandom()), VW'($urandom()));

        // Identity A, B[k][j]=k+1, back-to-back; a start during FLUSH must be ignored.
        n_done = 0;
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < D; k++) cycle(1'b0, 1'b1, ident_col(k), const_row(k));
        cycle(1'b1, 1'b0, '0, '0);
        repeat (D + 3) cycle(1'b0, 1'b0, '0, '0);
        chk("done_once_ident", 64'(n_done), 64'd1);
        chk("idle_after_ident", 64'(o_busy), 64'd0);

        // Three stall cycles after the first beat keep the skew frozen.
        n_done = 0;
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, ident_col(0), const_row(0));
        repeat (3) cycle(1'b0, 1'b0, VW'($urandom()), VW'($urandom()));
        for (int k = 1; k < D; k++) cycle(1'b0, 1'b1, ident_col(k), const_row(k));
        repeat (D + 2) cycle(1'b0, 1'b0, '0, '0);
        chk("done_once_stall", 64'(n_done), 64'd1);

        // Asynchronous reset mid-STREAM after two beats, then a clean restart.
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b1, VW'($urandom()), VW'($urandom()));
        cycle(1'b0, 1'b1, VW'($urandom()), VW'($urandom()));
        i_reset = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        cycle(1'b0, 1'b1, VW'($urandom()), VW'($urandom()));
        n_done = 0;
        cycle(1'b1, 1'b0, '0, '0);
        chk("restart_clear_token", 64'(dut.state_q), 64'(systolic_pkg::ST_CLEAR));
        for (int k = 0; k < D; k++) cycle(1'b0, 1'b1, VW'($urandom()), VW'($urandom()));
        cycle(1'b0, 1'b1, VW'($urandom()), VW'($urandom()));
        repeat (D + 2) cycle(1'b0, 1'b0, '0, '0);
        chk("done_once_restart", 64'(n_done), 64'd1);

        // Random products with random valid gaps and stray start pulses.
        for (int p = 0; p < 8; p++) begin
            int budget;
            n_done = 0;
            budget = 0;
            cycle(1'b1, 1'b0, '0, '0);
            while (phase != 0 && budget < 80) begin
                cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0),
                      VW'($urandom()), VW'($urandom()));
                budget++;
            end
            chk("rand_product_bound", 64'(budget < 80), 64'd1);
            chk("rand_done_once", 64'(n_done), 64'd1);
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b1, VW'($urandom()), VW'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
